// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer types, response codes and default-slave states
package ahb_pkg;
    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dflt_state_t;
    function automatic logic is_active(input logic [1:0] t);
        return (t == TR_NONSEQ) || (t == TR_SEQ);
    endfunction
endpackage

// File: rtl/ahb_interconnect_if.sv
// ahb_interconnect_if: master-side and slave-side AHB-Lite signals of the interconnect
interface ahb_interconnect_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]            HADDR;
    logic [1:0]                       HTRANS;
    logic [NUM_SLAVES-1:0]            HSEL;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S;
    logic [NUM_SLAVES-1:0]            HREADYOUT_S;
    logic [NUM_SLAVES-1:0]            HRESP_S;
    logic [DATA_WIDTH-1:0]            HRDATA;
    logic                             HREADY;
    logic                             HRESP;
    logic                             dec_err;
    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADY, HRESP, dec_err
    );
    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADY, HRESP, dec_err
    );
endinterface

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped active transfers
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic HCLK,
    input  logic HRESETn,
    input  logic req,
    output logic hready,
    output logic hresp,
    output logic dec_err
);
    dflt_state_t state_q, state_d;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= DS_IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = DS_IDLE;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        dec_err = 1'b0;
        case (state_q)
            DS_IDLE: state_d = req ? DS_ERR1 : DS_IDLE;
            DS_ERR1: begin
                state_d = DS_ERR2;
                hready  = 1'b0;
                hresp   = HRESP_ERROR;
                dec_err = 1'b1;
            end
            DS_ERR2: begin
                state_d = req ? DS_ERR1 : DS_IDLE;
                hresp   = HRESP_ERROR;
            end
            default: state_d = DS_IDLE;
        endcase
    end
endmodule

// File: rtl/ahb_interconnect.sv
// ahb_interconnect: single-master AHB-Lite decoder, data-phase response mux and default slave
module ahb_interconnect
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_BASE =
        {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLV_MASK = {4{32'hFFFF_F000}}
) (
    input logic HCLK,
    input logic HRESETn,
    ahb_interconnect_if.slave bus
);
    localparam int SW = $clog2(NUM_SLAVES + 1);
    localparam logic [SW-1:0] DEFAULT = SW'(NUM_SLAVES);
    logic [SW-1:0] asel, dsel_q, dsel_d;
    logic dflt_req, dflt_hready, dflt_hresp;
    // descending scan so the lowest matching index is the one that sticks
    always_comb begin
        asel = DEFAULT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((bus.HADDR & SLV_MASK[i]) == SLV_BASE[i]) asel = SW'(i);
    end
    always_comb begin
        bus.HSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) bus.HSEL[i] = (asel == SW'(i));
    end
    always_comb begin
        dsel_d   = bus.HREADY ? asel : dsel_q;
        dflt_req = (asel == DEFAULT) && is_active(bus.HTRANS) && bus.HREADY;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dsel_q <= DEFAULT;
        else          dsel_q <= dsel_d;
    end
    always_comb begin
        bus.HRDATA = '0;
        bus.HREADY = dflt_hready;
        bus.HRESP  = dflt_hresp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q == SW'(i)) begin
                bus.HRDATA = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                bus.HREADY = bus.HREADYOUT_S[i];
                bus.HRESP  = bus.HRESP_S[i];
            end
        end
    end
    ahb_default_slave u_dflt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (dflt_req),
        .hready  (dflt_hready),
        .hresp   (dflt_hresp),
        .dec_err (bus.dec_err)
    );
endmodule

// File: tb/tb_ahb_interconnect.sv
// tb_ahb_interconnect: directed and random checks of the interconnect against a transfer-level model
module tb_ahb_interconnect;
    import ahb_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_interconnect_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    ahb_interconnect_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ov ();

    ahb_interconnect #(
        .NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLV_BASE({32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK({3{32'hFFFF_F000}})
    ) dut (.HCLK(clk), .HRESETn(rst_n), .bus(bus));

    ahb_interconnect #(
        .NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SLV_BASE({32'h0000_2000, 32'h0000_0000, 32'h0000_0000}),
        .SLV_MASK({3{32'hFFFF_F000}})
    ) dut_ov (.HCLK(clk), .HRESETn(rst_n), .bus(ov));

    int checks = 0;
    int errors = 0;
    logic [31:0] base_a [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000};
    // owner of the current data phase: 0..2 mapped slave, 3 unmapped
    int dp_tgt = 3;
    bit dp_act = 1'b0;
    int dp_cyc = 0;
    bit p_er = 1'b1;
    bit p_dec = 1'b0;
    logic [31:0] p_addr = '0;
    logic [1:0] p_trans = '0;
    logic [31:0] cur_a = '0;
    logic [1:0] cur_t = '0;

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 3; i++) if ((a & 32'hFFFF_F000) == base_a[i]) return i;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rnd, input logic [31:0] a, input logic [1:0] t,
                       input logic [2:0] rdy, input logic [2:0] rsp,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] d [3];
        logic [31:0] ed;
        logic er, ep, edec;
        logic [2:0] ehs;
        int r;
        @(posedge clk);
        if (!rst_n) begin
            dp_tgt = 3; dp_act = 1'b0; dp_cyc = 0;
        end else if (p_er) begin
            dp_tgt = decode(p_addr); dp_act = p_trans[1]; dp_cyc = 0;
        end else dp_cyc++;
        #1;
        d[0] = d0; d[1] = d1; d[2] = d2;
        if (rnd) begin
            if (p_er || p_dec) begin
                r = $urandom_range(0, 4);
                cur_a = (r < 3) ? (base_a[r] | ($urandom & 32'h0000_0FFC)) : ($urandom | 32'h0001_0000);
                cur_t = 2'($urandom_range(0, 3));
            end
            for (int i = 0; i < 3; i++) begin
                rdy[i] = ($urandom_range(0, 2) != 0);
                rsp[i] = ($urandom_range(0, 7) == 0);
                d[i] = $urandom;
            end
        end else begin
            cur_a = a; cur_t = t;
        end
        bus.HADDR = cur_a;
        bus.HTRANS = cur_t;
        bus.HREADYOUT_S = rdy;
        bus.HRESP_S = rsp;
        bus.HRDATA_S = {d[2], d[1], d[0]};
        #3;
        er = 1'b1; ep = 1'b0; ed = '0; edec = 1'b0;
        if (rst_n) begin
            if (dp_tgt < 3) begin
                er = rdy[dp_tgt]; ep = rsp[dp_tgt]; ed = d[dp_tgt];
            end else if (dp_act) begin
                er = (dp_cyc != 0); ep = 1'b1; edec = (dp_cyc == 0);
            end
        end
        ehs = (decode(cur_a) < 3) ? 3'(1 << decode(cur_a)) : 3'b000;
        chk("hsel", 32'(bus.HSEL), 32'(ehs));
        chk("hready", 32'(bus.HREADY), 32'(er));
        chk("hresp", 32'(bus.HRESP), 32'(ep));
        chk("hrdata", bus.HRDATA, ed);
        chk("dec_err", 32'(bus.dec_err), 32'(edec));
        p_er = er; p_dec = edec; p_addr = cur_a; p_trans = cur_t;
    endtask

    initial begin
        bus.HADDR = '0; bus.HTRANS = TR_IDLE; bus.HREADYOUT_S = '1; bus.HRESP_S = '0; bus.HRDATA_S = '0;
        ov.HADDR = 32'h10; ov.HTRANS = TR_IDLE; ov.HREADYOUT_S = '1; ov.HRESP_S = '0; ov.HRDATA_S = '0;

        // reset values; HSEL still decodes
        cyc(0, 32'h0000_1004, TR_IDLE, 3'b111, 3'b000, 32'hA0, 32'hA1, 32'hA2);
        chk("rst_hsel", 32'(bus.HSEL), 32'h2);
        chk("rst_hready", 32'(bus.HREADY), 32'h1);
        @(negedge clk) rst_n = 1'b1;

        // slave1 read with two wait states
        cyc(0, 32'h0000_1004, TR_NONSEQ, 3'b111, 3'b000, 32'hB0, 32'hB1, 32'hB2);
        chk("rd1_hsel", 32'(bus.HSEL), 32'h2);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b101, 3'b000, 32'hB0, 32'hB1, 32'hB2);
        chk("rd1_wait1", 32'(bus.HREADY), 32'h0);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b101, 3'b000, 32'hB0, 32'hB1, 32'hB2);
        chk("rd1_wait2", 32'(bus.HREADY), 32'h0);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hB0, 32'hCAFE_0001, 32'hB2);
        chk("rd1_data", bus.HRDATA, 32'hCAFE_0001);
        chk("rd1_resp", 32'(bus.HRESP), 32'h0);

        // unmapped NONSEQ; master drops to IDLE during ERR1
        cyc(0, 32'h0000_9000, TR_NONSEQ, 3'b111, 3'b000, 32'hC0, 32'hC1, 32'hC2);
        chk("um_hsel", 32'(bus.HSEL), 32'h0);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hC0, 32'hC1, 32'hC2);
        chk("um_err1", {29'd0, bus.HREADY, bus.HRESP, bus.dec_err}, 32'h3);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hC0, 32'hC1, 32'hC2);
        chk("um_err2", {29'd0, bus.HREADY, bus.HRESP, bus.dec_err}, 32'h6);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hC0, 32'hC1, 32'hC2);
        chk("um_okay", {29'd0, bus.HREADY, bus.HRESP, bus.dec_err}, 32'h4);

        // slave0 read, unmapped write, slave2 read pipelined
        cyc(0, 32'h0000_0000, TR_NONSEQ, 3'b111, 3'b000, 32'hD0, 32'hD1, 32'hD2);
        cyc(0, 32'h0000_8000, TR_NONSEQ, 3'b111, 3'b000, 32'h1111_0000, 32'hD1, 32'hD2);
        chk("pipe_s0", bus.HRDATA, 32'h1111_0000);
        cyc(0, 32'h0000_2000, TR_NONSEQ, 3'b111, 3'b000, 32'hD0, 32'hD1, 32'hD2);
        chk("pipe_err1", 32'(bus.dec_err), 32'h1);
        cyc(0, 32'h0000_2000, TR_NONSEQ, 3'b111, 3'b000, 32'hD0, 32'hD1, 32'hD2);
        chk("pipe_err2_hsel", 32'(bus.HSEL), 32'h4);
        chk("pipe_err2_rdy", {30'd0, bus.HREADY, bus.HRESP}, 32'h3);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hD0, 32'hD1, 32'h2222_BEEF);
        chk("pipe_s2", bus.HRDATA, 32'h2222_BEEF);

        // unmapped IDLE is a zero-wait OKAY
        cyc(0, 32'hF000_0000, TR_IDLE, 3'b111, 3'b000, 32'hE0, 32'hE1, 32'hE2);
        cyc(0, 32'hF000_0000, TR_IDLE, 3'b111, 3'b000, 32'hE0, 32'hE1, 32'hE2);
        chk("uidle", {29'd0, bus.HREADY, bus.HRESP, bus.dec_err}, 32'h4);

        // overlapping regions resolve to the lowest index
        ov.HADDR = 32'h0000_0010;
        #1 chk("ov_low", 32'(ov.HSEL), 32'h1);
        ov.HADDR = 32'h0000_2010;
        #1 chk("ov_s2", 32'(ov.HSEL), 32'h4);

        // reset asserted during ERR1
        cyc(0, 32'h0000_9000, TR_NONSEQ, 3'b111, 3'b000, 32'hF0, 32'hF1, 32'hF2);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hF0, 32'hF1, 32'hF2);
        chk("rst_err1", 32'(bus.dec_err), 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {bus.HRDATA[28:0], bus.HREADY, bus.HRESP, bus.dec_err}, 32'h4);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hF0, 32'hF1, 32'hF2);
        @(negedge clk) rst_n = 1'b1;
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hF0, 32'hF1, 32'hF2);
        cyc(0, 32'h0000_0000, TR_IDLE, 3'b111, 3'b000, 32'hF0, 32'hF1, 32'hF2);
        chk("rst_after", {30'd0, bus.HREADY, bus.HRESP}, 32'h2);

        for (int n = 0; n < 400; n++) cyc(1, '0, TR_IDLE, 3'b111, 3'b000, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
